lookup_req_arbiter: RTL and testbench

LOOKUP_REQ_ARBITER -- requirements
Module: lookup_req_arbiter

---
 rtl/lookup_req_arbiter_pkg.sv | 19 +
 rtl/lookup_req_arbiter_if.sv | 28 ++
 rtl/lookup_req_arbiter_tag.sv | 46 ++++
 rtl/lookup_req_arbiter.sv | 85 ++++++++
 tb/tb_lookup_req_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/lookup_req_arbiter_pkg.sv
// lookup_req_arbiter_pkg: shared path-data layout, error-bit indices and arbiter state type
package lookup_req_arbiter_pkg;
    localparam int PATH_W       = 144;
    localparam int NH_MAC_W     = 48;
    localparam int NH_QP_W      = 16;
    localparam int NH_PORT_W    = 16;
    localparam int NH_IP_W      = 32;
    localparam int OUT_QP_W     = 16;
    localparam int OUT_PORT_W   = 16;
    localparam int NH_MAC_LSB   = 0;
    localparam int NH_QP_LSB    = NH_MAC_LSB + NH_MAC_W;
    localparam int NH_PORT_LSB  = NH_QP_LSB + NH_QP_W;
    localparam int NH_IP_LSB    = NH_PORT_LSB + NH_PORT_W;
    localparam int OUT_QP_LSB   = NH_IP_LSB + NH_IP_W;
    localparam int OUT_PORT_LSB = OUT_QP_LSB + OUT_QP_W;
    localparam int ERR_SPURIOUS = 0;
    localparam int ERR_TIMEOUT  = 1;
    typedef enum logic {HOLD, RUN} arb_state_t;
endpackage

// File: rtl/lookup_req_arbiter_if.sv
// lookup_req_arbiter_if: requester-side and lookup-side handshake bundle of the arbiter
interface lookup_req_arbiter_if
    import lookup_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_src_sw;
    logic [6*NUM_REQ-1:0] req_dst_host;
    logic                 lk_req_valid;
    logic [3:0]           lk_src_sw;
    logic [5:0]           lk_dst_host;
    logic                 lk_resp_valid;
    logic                 lk_path_valid;
    logic [PATH_W-1:0]    lk_path_data;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic                 rsp_path_valid;
    logic [PATH_W-1:0]    rsp_path_data;
    modport slave (
        input  req_valid, req_src_sw, req_dst_host, lk_resp_valid, lk_path_valid, lk_path_data,
        output req_ready, lk_req_valid, lk_src_sw, lk_dst_host, rsp_valid, rsp_path_valid, rsp_path_data
    );
    modport master (
        output req_valid, req_src_sw, req_dst_host, lk_resp_valid, lk_path_valid, lk_path_data,
        input  req_ready, lk_req_valid, lk_src_sw, lk_dst_host, rsp_valid, rsp_path_valid, rsp_path_data
    );
endinterface

// File: rtl/lookup_req_arbiter_tag.sv
// lookup_tag_fifo: in-order FIFO of requester tags for outstanding lookups, count-based full/empty
module lookup_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          wr, rd;
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign head  = mem[rp];
    // pointers wrap naturally; the count alone decides full and empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wr ? wp + 1'b1 : wp;
            rp    <= rd ? rp + 1'b1 : rp;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    // tag storage, no reset needed since reads are qualified by the count
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
endmodule

// File: rtl/lookup_req_arbiter.sv
// lookup_req_arbiter: round-robin sharing of the lookup port with in-order response routing (optional watchdog: LOOKUP_ARB_TIMEOUT_EN)
module lookup_req_arbiter
    import lookup_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TAG_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       system_ready,
    lookup_req_arbiter_if.slave        rif,
    output logic [$clog2(TAG_DEPTH):0] outstanding,
    output logic [1:0]                 err_sticky
);
    localparam int TW = $clog2(NUM_REQ);
    arb_state_t    state;
    logic [TW-1:0] ptr, win, head;
    logic          hit, grant_en, push, pop, spur, flush, empty, full;
    // first valid requester after the last grant, wrapping at NUM_REQ-1
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!hit && rif.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                hit = 1'b1;
                win = TW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
    assign grant_en      = state == RUN && system_ready && !full && !flush;
    assign rif.req_ready = (grant_en && hit) ? NUM_REQ'(1) << win : '0;
    assign push          = |rif.req_ready;
    assign pop           = rif.lk_resp_valid && !empty && !flush;
    assign spur          = rif.lk_resp_valid && (empty || flush);
    lookup_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (win),
        .pop   (pop),
        .head  (head),
        .count (outstanding),
        .empty (empty),
        .full  (full)
    );
`ifdef LOOKUP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo;
    assign flush = tmo == CW'(TIMEOUT_CYC);
    // watchdog counts silent cycles while lookups are in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo <= '0;
        else        tmo <= (outstanding != '0 && !rif.lk_resp_valid && !flush) ? tmo + 1'b1 : '0;
    end
`else
    assign flush = 1'b0;
`endif
    // state, round-robin pointer, registered lookup request/response and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= HOLD;
            ptr                <= TW'(NUM_REQ - 1);
            rif.lk_req_valid   <= 1'b0;
            rif.lk_src_sw      <= '0;
            rif.lk_dst_host    <= '0;
            rif.rsp_valid      <= '0;
            rif.rsp_path_valid <= 1'b0;
            rif.rsp_path_data  <= '0;
            err_sticky         <= '0;
        end else begin
            state                   <= system_ready ? RUN : HOLD;
            ptr                     <= push ? win : ptr;
            rif.lk_req_valid        <= push;
            rif.lk_src_sw           <= push ? rif.req_src_sw[int'(win)*4 +: 4] : rif.lk_src_sw;
            rif.lk_dst_host         <= push ? rif.req_dst_host[int'(win)*6 +: 6] : rif.lk_dst_host;
            rif.rsp_valid           <= pop ? NUM_REQ'(1) << head : '0;
            rif.rsp_path_valid      <= pop && rif.lk_path_valid;
            rif.rsp_path_data       <= pop ? rif.lk_path_data : rif.rsp_path_data;
            err_sticky[ERR_SPURIOUS] <= err_sticky[ERR_SPURIOUS] | spur;
            err_sticky[ERR_TIMEOUT]  <= err_sticky[ERR_TIMEOUT] | flush;
        end
    end
endmodule

// File: tb/tb_lookup_req_arbiter.sv
// tb_lookup_req_arbiter: scoreboard bench for grant order, lookup issue, response routing and error flags
module tb_lookup_req_arbiter;
    typedef struct {logic [3:0] sw; logic [5:0] host;} lk_t;
    typedef struct {logic [3:0] oh; logic pv; logic [143:0] data;} rsp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       system_ready = 1'b0;
    logic [3:0] outstanding;
    logic [1:0] err_sticky;
    lk_t        lk_q[$];
    rsp_t       rsp_q[$];
    int         tag_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         exp_e0, exp_e1;
    bit         chk_out = 1'b1;
    logic [3:0] sw_a[4];
    logic [5:0] host_a[4];
    always #5 clk = ~clk;
    lookup_req_arbiter_if #(.NUM_REQ(4)) rif();
    lookup_req_arbiter #(.NUM_REQ(4), .TAG_DEPTH(8), .TIMEOUT_CYC(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .system_ready (system_ready),
        .rif          (rif),
        .outstanding  (outstanding),
        .err_sticky   (err_sticky)
    );
    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        system_ready = 1'b1;
        rif.req_valid = 4'hF;
        rif.lk_resp_valid = 1'b0;
        lk_q.delete();
        rsp_q.delete();
        tag_q.delete();
        exp_e0 = 1'b0;
        exp_e1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", rif.req_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_lk_req_valid", rif.lk_req_valid, 0);
        chk("rst_lk_fields", {rif.lk_src_sw, rif.lk_dst_host}, 0);
        chk("rst_rsp_valid", rif.rsp_valid, 0);
        chk("rst_rsp_path_valid", rif.rsp_path_valid, 0);
        chk("rst_rsp_path_data", rif.rsp_path_data, 0);
        system_ready = 1'b0;
        rif.req_valid = 4'h0;
        rst_n = 1'b1;
    endtask
    task automatic tick(input logic [3:0] exp_ready, input bit resp);
        rsp_t r;
        lk_t  l;
        int   idx;
        if (resp) begin
            rif.lk_resp_valid = 1'b1;
            rif.lk_path_valid = 1'($urandom);
            rif.lk_path_data  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
        end
        #1;
        chk("req_ready", rif.req_ready, exp_ready);
        if (resp) begin
            if (tag_q.size() > 0) begin
                r.oh = 4'(1) << tag_q.pop_front();
                r.pv = rif.lk_path_valid;
                r.data = rif.lk_path_data;
                rsp_q.push_back(r);
            end else exp_e0 = 1'b1;
        end
        if (exp_ready != 4'h0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
            l.sw = sw_a[idx];
            l.host = host_a[idx];
            lk_q.push_back(l);
            tag_q.push_back(idx);
        end
        @(posedge clk);
        #1;
        rif.lk_resp_valid = 1'b0;
        if (lk_q.size() > 0) begin
            l = lk_q.pop_front();
            chk("lk_req_valid", rif.lk_req_valid, 1);
            chk("lk_src_sw", rif.lk_src_sw, l.sw);
            chk("lk_dst_host", rif.lk_dst_host, l.host);
        end else chk("lk_req_idle", rif.lk_req_valid, 0);
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            chk("rsp_valid", rif.rsp_valid, r.oh);
            chk("rsp_path_valid", rif.rsp_path_valid, r.pv);
            chk("rsp_path_data", rif.rsp_path_data, r.data);
        end else begin
            chk("rsp_idle", rif.rsp_valid, 0);
            chk("rsp_path_idle", rif.rsp_path_valid, 0);
        end
        if (chk_out) begin
            chk("outstanding", outstanding, tag_q.size());
            chk("err_sticky", err_sticky, {exp_e1, exp_e0});
        end
    endtask
    initial begin
        for (int i = 0; i < 4; i++) begin
            sw_a[i] = 4'(i + 1);
            host_a[i] = 6'(i * 9);
            rif.req_src_sw[i*4 +: 4] = sw_a[i];
            rif.req_dst_host[i*6 +: 6] = host_a[i];
        end
        rif.lk_path_valid = 1'b0;
        rif.lk_path_data = '0;
        do_reset();
        system_ready = 1'b1;
        tick(4'h0, 0);
        rif.req_valid = 4'h1;
        tick(4'h1, 0);
        rif.req_valid = 4'h0;
        tick(4'h0, 1);
        do_reset();
        system_ready = 1'b1;
        rif.req_valid = 4'hF;
        tick(4'h0, 0);
        for (int i = 0; i < 8; i++) tick(4'(1) << (i % 4), 0);
        tick(4'h0, 0);
        tick(4'h0, 1);
        tick(4'h1, 1);
        chk("same_cycle_push_pop", outstanding, 7);
        rif.req_valid = 4'h0;
        for (int i = 0; i < 7; i++) tick(4'h0, 1);
        tick(4'h0, 1);
        chk("spurious_err", err_sticky, 2'b01);
        rif.req_valid = 4'hF;
        tick(4'h2, 0);
        tick(4'h4, 0);
        tick(4'h8, 0);
        system_ready = 1'b0;
        tick(4'h0, 0);
        for (int i = 0; i < 3; i++) tick(4'h0, 1);
        chk("drain_after_hold", outstanding, 0);
        rif.req_valid = 4'h1;
        system_ready = 1'b1;
        tick(4'h0, 0);
        tick(4'h1, 0);
        do_reset();
        tick(4'h0, 1);
        chk("spurious_after_reset", err_sticky, 2'b01);
`ifdef LOOKUP_ARB_TIMEOUT_EN
        do_reset();
        system_ready = 1'b1;
        rif.req_valid = 4'hF;
        tick(4'h0, 0);
        tick(4'h1, 0);
        tick(4'h2, 0);
        rif.req_valid = 4'h0;
        for (int i = 0; i < 55; i++) tick(4'h0, 0);
        chk_out = 1'b0;
        for (int i = 0; i < 20 && outstanding != 0; i++) tick(4'h0, 0);
        tag_q.delete();
        chk("timeout_outstanding", outstanding, 0);
        chk("timeout_err", err_sticky, 2'b10);
        exp_e1 = 1'b1;
        chk_out = 1'b1;
        tick(4'h0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
